// File: rtl/snapshot_sequencer.sv
// Debug snapshot engine: on each falling edge of v_sync_in, copies the CPU registers and
// NUM_WINDOWS memory windows (each centred on its own pointer) into the aux display RAM.
module snapshot_sequencer #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned MEM_ADDR_WIDTH   = 11,
  parameter int unsigned AUX_ADDR_WIDTH   = 5,
  parameter int unsigned CPU_ELEMENTS     = 10,
  parameter int unsigned NUM_WINDOWS      = 2,
  parameter int unsigned WINDOW_SIZE      = 10,
  parameter int unsigned WINDOW_BEFORE    = 4,
  parameter int unsigned MEM_READ_LATENCY = 1
) (
  input  logic                                  clock_in,
  input  logic                                  reset_in,
  input  logic                                  v_sync_in,
  input  logic [DATA_WIDTH-1:0]                 cpu_content_in,
  output logic [CPU_ELEMENTS-1:0]               cpu_select_out,
  input  logic [NUM_WINDOWS*MEM_ADDR_WIDTH-1:0] center_in,
  input  logic [NUM_WINDOWS*DATA_WIDTH-1:0]     mem_data_in,
  output logic [NUM_WINDOWS-1:0]                mem_select_out,
  output logic [MEM_ADDR_WIDTH-1:0]             mem_address_out,
  output logic                                  aux_wr_out,
  output logic [AUX_ADDR_WIDTH-1:0]             aux_waddress_out,
  output logic [DATA_WIDTH-1:0]                 aux_data_out,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic                                  overrun_out
);

  localparam int unsigned MaxCnt = (CPU_ELEMENTS > WINDOW_SIZE) ? CPU_ELEMENTS : WINDOW_SIZE;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned WinW   = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int unsigned LatW   = (MEM_READ_LATENCY > 0) ? $clog2(MEM_READ_LATENCY + 1) : 1;
  // One extra bit so that centre - WINDOW_BEFORE and the upper clamp never wrap.
  localparam int unsigned BaseW  = MEM_ADDR_WIDTH + 1;

  localparam logic [BaseW-1:0] BeforeB  = BaseW'(WINDOW_BEFORE);
  localparam logic [BaseW-1:0] LimitB   = BaseW'((2 ** MEM_ADDR_WIDTH) - WINDOW_SIZE);
  localparam logic [CntW-1:0]  LastCpu  = CntW'(CPU_ELEMENTS - 1);
  localparam logic [CntW-1:0]  LastElem = CntW'(WINDOW_SIZE - 1);
  localparam logic [WinW-1:0]  LastWin  = WinW'(NUM_WINDOWS - 1);
  localparam logic [LatW-1:0]  LastLat  = LatW'(MEM_READ_LATENCY);

  typedef enum logic [2:0] {
    StIdle,
    StCpuRead,
    StWinSetup,
    StWinRead,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    vs_q, vs_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WinW-1:0]         win_q, win_d;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [BaseW-1:0]        base_q, base_d;
  logic                    aux_wr_q, aux_wr_d;
  logic [AUX_ADDR_WIDTH-1:0] aux_addr_q, aux_addr_d;
  logic [DATA_WIDTH-1:0]   aux_data_q, aux_data_d;

  logic                      trigger;
  logic [MEM_ADDR_WIDTH-1:0] center_sel;
  logic [BaseW-1:0]          center_ext;
  logic [BaseW-1:0]          offset;
  logic [BaseW-1:0]          base_calc;
  logic [DATA_WIDTH-1:0]     mem_sel_data;

  // Window base for the current channel: clamp at the bottom and top of memory.
  always_comb begin
    center_sel   = center_in[32'(win_q) * MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    mem_sel_data = mem_data_in[32'(win_q) * DATA_WIDTH +: DATA_WIDTH];
    center_ext   = {1'b0, center_sel};
    offset       = center_ext - BeforeB;
    if (center_ext < BeforeB) begin
      base_calc = '0;
    end else if (offset > LimitB) begin
      base_calc = LimitB;
    end else begin
      base_calc = offset;
    end
  end

  // Sequencer next state, select/address outputs and aux write staging.
  always_comb begin
    state_d         = state_q;
    vs_d            = v_sync_in;
    cnt_d           = cnt_q;
    win_d           = win_q;
    lat_d           = lat_q;
    base_d          = base_q;
    aux_wr_d        = 1'b0;
    aux_addr_d      = aux_addr_q;
    aux_data_d      = aux_data_q;
    cpu_select_out  = '0;
    mem_select_out  = '0;
    mem_address_out = '0;
    done_out        = 1'b0;

    trigger     = vs_q & ~v_sync_in;
    busy_out    = (state_q != StIdle);
    overrun_out = trigger & (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StCpuRead;
          cnt_d   = '0;
          win_d   = '0;
        end
      end
      StCpuRead: begin
        cpu_select_out = CPU_ELEMENTS'(1) << cnt_q;
        aux_data_d     = cpu_content_in;
        aux_addr_d     = AUX_ADDR_WIDTH'(cnt_q);
        aux_wr_d       = 1'b1;
        if (cnt_q == LastCpu) begin
          state_d = StWinSetup;
          cnt_d   = '0;
          win_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWinSetup: begin
        base_d  = base_calc;
        cnt_d   = '0;
        lat_d   = '0;
        state_d = StWinRead;
      end
      StWinRead: begin
        mem_select_out  = NUM_WINDOWS'(1) << win_q;
        mem_address_out = MEM_ADDR_WIDTH'(base_q + BaseW'(cnt_q));
        // Address is held for the whole element; data is taken on its last cycle.
        if (lat_q == LastLat) begin
          lat_d      = '0;
          aux_data_d = mem_sel_data;
          aux_addr_d = AUX_ADDR_WIDTH'(CPU_ELEMENTS + 32'(win_q) * WINDOW_SIZE + 32'(cnt_q));
          aux_wr_d   = 1'b1;
          if (cnt_q == LastElem) begin
            cnt_d = '0;
            if (win_q == LastWin) begin
              state_d = StDone;
            end else begin
              win_d   = win_q + 1'b1;
              state_d = StWinSetup;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StDone: begin
        done_out = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; vsync history resets high to avoid a false edge.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= StIdle;
      vs_q       <= 1'b1;
      cnt_q      <= '0;
      win_q      <= '0;
      lat_q      <= '0;
      base_q     <= '0;
      aux_wr_q   <= 1'b0;
      aux_addr_q <= '0;
      aux_data_q <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      lat_q      <= lat_d;
      base_q     <= base_d;
      aux_wr_q   <= aux_wr_d;
      aux_addr_q <= aux_addr_d;
      aux_data_q <= aux_data_d;
    end
  end

  assign aux_wr_out       = aux_wr_q;
  assign aux_waddress_out = aux_addr_q;
  assign aux_data_out     = aux_data_q;

endmodule

// File: tb/tb_snapshot_sequencer.sv
// Self-checking bench for snapshot_sequencer: memory and aux RAM models, randomized snapshots.
module tb_snapshot_sequencer;
  localparam int DW  = 16;
  localparam int MAW = 11;
  localparam int AAW = 5;
  localparam int CE  = 10;
  localparam int NW  = 2;
  localparam int WS  = 10;
  localparam int WB  = 4;
  localparam int MemWords = 2048;
  localparam int Total    = CE + NW * WS;

  logic              clk = 1'b0;
  logic              reset_in;
  logic              v_sync_in;
  logic [DW-1:0]     cpu_content_in;
  logic [CE-1:0]     cpu_select_out;
  logic [NW*MAW-1:0] center_in;
  logic [NW*DW-1:0]  mem_data_in;
  logic [NW-1:0]     mem_select_out;
  logic [MAW-1:0]    mem_address_out;
  logic              aux_wr_out;
  logic [AAW-1:0]    aux_waddress_out;
  logic [DW-1:0]     aux_data_out;
  logic              busy_out;
  logic              done_out;
  logic              overrun_out;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]  mem [NW][MemWords];
  logic [DW-1:0]  rd_q [NW];
  logic [DW-1:0]  cpu_regs [CE];
  logic [MAW-1:0] center [NW];
  logic [DW-1:0]  aux_m [32];

  always #5 clk = ~clk;

  snapshot_sequencer dut (
    .clock_in         (clk),
    .reset_in         (reset_in),
    .v_sync_in        (v_sync_in),
    .cpu_content_in   (cpu_content_in),
    .cpu_select_out   (cpu_select_out),
    .center_in        (center_in),
    .mem_data_in      (mem_data_in),
    .mem_select_out   (mem_select_out),
    .mem_address_out  (mem_address_out),
    .aux_wr_out       (aux_wr_out),
    .aux_waddress_out (aux_waddress_out),
    .aux_data_out     (aux_data_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .overrun_out      (overrun_out)
  );

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) rd_q[w] <= mem[w][mem_address_out];
  end
  assign mem_data_in = {rd_q[1], rd_q[0]};
  assign center_in   = {center[1], center[0]};

  always_comb begin
    cpu_content_in = '0;
    for (int k = 0; k < CE; k++) if (cpu_select_out[k]) cpu_content_in = cpu_regs[k];
  end

  // Expected aux contents derived from the window rules.
  function automatic logic [DW-1:0] exp_aux(input int idx);
    int w, j, c, base;
    if (idx < CE) return cpu_regs[idx];
    w = (idx - CE) / WS;
    j = (idx - CE) % WS;
    c = int'(center[w]);
    if (c < WB) base = 0;
    else begin
      base = c - WB;
      if (base > MemWords - WS) base = MemWords - WS;
    end
    return mem[w][base + j];
  endfunction

  // Fire one snapshot at cycle 0 and record 80 cycles of behaviour.
  task automatic watch(input int reset_at, input int retrig_at, output int done_cyc,
                       output int n_done, output int n_over, output int n_wr,
                       output int first_addr, output int conflicts);
    done_cyc = -1; n_done = 0; n_over = 0; n_wr = 0; first_addr = -1; conflicts = 0;
    for (int i = 0; i < 32; i++) aux_m[i] = 'x;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 0) v_sync_in = 1'b0;
      if (cyc == 2) v_sync_in = 1'b1;
      if (retrig_at >= 0 && cyc == retrig_at) v_sync_in = 1'b0;
      if (retrig_at >= 0 && cyc == retrig_at + 2) v_sync_in = 1'b1;
      reset_in = (cyc == reset_at);
      #1;
      if (aux_wr_out) begin
        n_wr++;
        if (first_addr < 0) first_addr = int'(aux_waddress_out);
        aux_m[aux_waddress_out] = aux_data_out;
      end
      if (done_out) begin n_done++; done_cyc = cyc; end
      if (overrun_out) n_over++;
      if (cpu_select_out != '0 && mem_select_out != '0) conflicts++;
      if (reset_at >= 0 && cyc == reset_at + 1) begin
        checks++;
        if ({aux_wr_out, busy_out} !== 2'b00) begin
          errors++;
          $display("FAIL reset_abort: wr/busy=%b required 00", {aux_wr_out, busy_out});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    reset_in = 1'b1; v_sync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      outs = 64'({cpu_select_out, mem_select_out, mem_address_out, aux_wr_out, aux_waddress_out,
                  aux_data_out, busy_out, done_out, overrun_out});
      checks++;
      if (outs !== 64'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h required 0", i, outs);
      end
    end
  endtask

  task automatic test_cpu_capture();
    int dc, nd, no, nw, fa, cf;
    for (int k = 0; k < CE; k++) cpu_regs[k] = DW'(16'h1000 + k);
    center[0] = 11'h300; center[1] = 11'h500;
    watch(-1, -1, dc, nd, no, nw, fa, cf);
    checks++;
    if (dc !== 53 || nd !== 1) begin
      errors++; $display("FAIL cpu_done: cycle=%0d count=%0d required 53/1", dc, nd);
    end
    checks++;
    if (nw !== Total || no !== 0 || cf !== 0) begin
      errors++; $display("FAIL cpu_writes: wr=%0d over=%0d conf=%0d required 30/0/0", nw, no, cf);
    end
    for (int k = 0; k < CE; k++) begin
      checks++;
      if (aux_m[k] !== DW'(16'h1000 + k)) begin
        errors++; $display("FAIL cpu_aux[%0d]: got %h required %h", k, aux_m[k], 16'h1000 + k);
      end
    end
  endtask

  task automatic test_window_edges();
    int dc, nd, no, nw, fa, cf;
    center[0] = 11'h002; center[1] = 11'h7FE;
    watch(-1, -1, dc, nd, no, nw, fa, cf);
    for (int j = 0; j < WS; j++) begin
      checks++;
      if (aux_m[CE + j] !== mem[0][j]) begin
        errors++; $display("FAIL edge_low[%0d]: got %h required %h", j, aux_m[CE + j], mem[0][j]);
      end
      checks++;
      if (aux_m[CE + WS + j] !== mem[1][11'h7F6 + j]) begin
        errors++;
        $display("FAIL edge_high[%0d]: got %h required %h", j, aux_m[CE + WS + j],
                 mem[1][11'h7F6 + j]);
      end
    end
  endtask

  task automatic test_window_mid();
    int dc, nd, no, nw, fa, cf;
    center[0] = 11'h100; center[1] = 11'h004;
    watch(-1, -1, dc, nd, no, nw, fa, cf);
    for (int j = 0; j < WS; j++) begin
      checks++;
      if (aux_m[CE + j] !== mem[0][11'h0FC + j]) begin
        errors++;
        $display("FAIL mid[%0d]: got %h required %h", j, aux_m[CE + j], mem[0][11'h0FC + j]);
      end
    end
    checks++;
    if (aux_m[CE + WS] !== mem[1][0]) begin
      errors++; $display("FAIL ctr4_base: got %h required %h", aux_m[CE + WS], mem[1][0]);
    end
  endtask

  task automatic test_random();
    int dc, nd, no, nw, fa, cf;
    int picks [8] = '{0, 3, 4, 5, 2041, 2042, 2043, 2047};
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < CE; k++) cpu_regs[k] = DW'($urandom);
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 1) == 0) center[w] = MAW'(picks[$urandom_range(0, 7)]);
        else center[w] = MAW'($urandom_range(0, MemWords - 1));
      end
      watch(-1, -1, dc, nd, no, nw, fa, cf);
      checks++;
      if (dc !== 53 || nw !== Total) begin
        errors++; $display("FAIL rand%0d_timing: done=%0d wr=%0d required 53/30", n, dc, nw);
      end
      for (int i = 0; i < Total; i++) begin
        checks++;
        if (aux_m[i] !== exp_aux(i)) begin
          errors++;
          $display("FAIL rand%0d_aux[%0d] c0=%h c1=%h: got %h required %h", n, i, center[0],
                   center[1], aux_m[i], exp_aux(i));
        end
      end
    end
  endtask

  task automatic test_overrun();
    int dc, nd, no, nw, fa, cf;
    int at [2] = '{20, 53};
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < CE; k++) cpu_regs[k] = DW'($urandom);
      center[0] = MAW'($urandom_range(0, MemWords - 1));
      center[1] = MAW'($urandom_range(0, MemWords - 1));
      watch(-1, at[t], dc, nd, no, nw, fa, cf);
      checks++;
      if (no !== 1 || nd !== 1 || dc !== 53 || nw !== Total) begin
        errors++;
        $display("FAIL overrun@%0d: over=%0d done=%0d@%0d wr=%0d required 1/1@53/30",
                 at[t], no, nd, dc, nw);
      end
      for (int i = 0; i < Total; i++) begin
        checks++;
        if (aux_m[i] !== exp_aux(i)) begin
          errors++; $display("FAIL overrun_aux[%0d]: got %h required %h", i, aux_m[i], exp_aux(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc, nd, no, nw, fa, cf;
    watch(15, -1, dc, nd, no, nw, fa, cf);
    checks++;
    if (nd !== 0) begin
      errors++; $display("FAIL reset_no_done: done count=%0d required 0", nd);
    end
    for (int k = 0; k < CE; k++) cpu_regs[k] = DW'($urandom);
    watch(-1, -1, dc, nd, no, nw, fa, cf);
    checks++;
    if (fa !== 0 || dc !== 53 || nw !== Total) begin
      errors++;
      $display("FAIL reset_restart: first=%0d done=%0d wr=%0d required 0/53/30", fa, dc, nw);
    end
    for (int i = 0; i < Total; i++) begin
      checks++;
      if (aux_m[i] !== exp_aux(i)) begin
        errors++; $display("FAIL restart_aux[%0d]: got %h required %h", i, aux_m[i], exp_aux(i));
      end
    end
  endtask

  initial begin
    reset_in  = 1'b1;
    v_sync_in = 1'b1;
    for (int w = 0; w < NW; w++) begin
      center[w] = '0;
      for (int a = 0; a < MemWords; a++) mem[w][a] = DW'($urandom);
    end
    for (int k = 0; k < CE; k++) cpu_regs[k] = '0;
    test_reset();
    test_cpu_capture();
    test_window_edges();
    test_window_mid();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
